elevator_call_dispatcher: RTL and testbench
===========================================

# elevator_call_dispatcher

Request-side counterpart of the elevator controller: collects per-floor call buttons, latches them as pending calls and schedules them in SCAN order. It drives the controller's 4-bit `requested_floor` input and consumes its `current_floor` and idle outputs. A call is cleared only when the car is idle at that floor, followed by a door dwell. Sits between the board inputs and the elevator state machine in the top level.

## Interface
- `NUM_FLOORS`, 10: number of floors, 2..16; floors are 0..NUM_FLOORS-1.
- `DWELL_CYCLES`, 8: door-open hold in clocks, ≥1; silicon builds use ~10_000_000.

- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `call_btn`  in  NUM_FLOORS: raw asynchronous call buttons, level, bit i = floor i.
- `current_floor`  in  4: car position from the controller.
- `car_idle`  in  1: controller idle indication.
- `requested_floor`  out  4: target floor for the controller, registered.
- `pending`  out  NUM_FLOORS: latched calls, for the call lamps.
- `busy`  out  1: state != IDLE.
- `door_open`  out  1: state == DWELL.

## Operation
- Inputs: each `call_btn` bit passes through a 2-flop synchronizer, then a rising-edge detector. An edge sets `pending[i]`. Holding a button sets the bit once.
- Serve condition, evaluated in IDLE, UP and DOWN:
  - `car_idle`=1, `requested_floor`==`current_floor`, and `pending[current_floor]`=1.
  - On it, clear that bit, load the dwell counter with DWELL_CYCLES-1, and go to DWELL.
  - Clear beats a same-cycle set on the same bit.
- If `current_floor` ≥ NUM_FLOORS: no clears, and no pending bits count as above or below.
- `dir` register remembers the last travel direction. Reset value: up.
- States:
  - IDLE:
    - `pending[current_floor]`: stay IDLE, request current floor.
    - Else any pending above: go UP, dir=up.
    - Else any pending below: go DOWN, dir=down.
    - Up wins a tie.
  - UP:
    - Request the lowest pending floor ≥ `current_floor`.
    - If none exists: go DOWN if any pending below, else IDLE.
  - DOWN:
    - Request the highest pending floor ≤ `current_floor`.
    - If none exists: go UP if any pending above, else IDLE.
  - DWELL:
    - Request `current_floor`.
    - A new edge on the current floor's button is discarded.
    - Counter decrements each clock. At 0, exit:
      - If dir=up: UP when pending above, else DOWN when pending below, else IDLE.
      - If dir=down: the mirror of this.
- `requested_floor` in IDLE with nothing pending: `current_floor`, so the car stays parked.
- Because UP and DOWN use ≥ and ≤, a car passing a pending floor retargets to that floor and stops there.

## Timing
- Reset values:
  - `pending`=0, `requested_floor`=0, `busy`=0, `door_open`=0.
  - State IDLE, dir=up, counter 0, synchronizer and edge flops 0.
- Button to `pending`: `call_btn` sampled high at edge k sets the bit at edge k+2. A press shorter than one clock may be lost.
- `pending` to `requested_floor`: next edge. `requested_floor` is computed from the registered pending and state.
- Serve: the serve condition true at edge n gives `door_open`=1 and the bit cleared after edge n. `door_open` stays 1 for exactly DWELL_CYCLES clocks.
- Reset asserted mid-operation: all state is dropped at the next edge, including pending calls.

## Structure
- Shared package holds:
  - State encoding: IDLE, UP, DOWN, DWELL.
  - `FLOOR_W`=4.
  - Default NUM_FLOORS and DWELL_CYCLES.
- Sub-module `call_sync_edge`: NUM_FLOORS-wide 2-flop synchronizer plus rising-edge pulse, same reset.
- Above/below and lowest/highest selection: combinational loops in the top module.

## Test plan
- Reset with all buttons high: `pending`=0 and `requested_floor`=0. Release and press floor 3 → `pending[3]` at edge k+2; `requested_floor`=3 next edge; `busy`=1.
- Car model at floor 0, calls 5 and 2 pressed together → served 2 then 5. Each serve gives `door_open` for 8 clocks, and the bit clears at serve.
- Car moving up from 0 toward 7 with a call at 4 added at floor 2 → `requested_floor` switches to 4. Car stops and serves 4, then resumes to 7.
- Car at floor 6 in DOWN with dir=down, calls 8 and 1 pending → 1 served before 8.
- Car idle at floor 3 and button 3 pressed → `pending[3]` pulses, then DWELL. Pressing 3 again during DWELL is ignored.
- `current_floor`=12 with NUM_FLOORS=10 and a call at 9 pending → no clear. Assert `rst_n`=0 mid-DWELL → all outputs return to reset values after one edge.

Source files
------------

// File: rtl/elevator_call_dispatcher_pkg.sv
// ----------------------------------------------------------------------------
// elevator_call_dispatcher_pkg
//   Shared definitions for the call dispatcher: scheduler state encoding,
//   floor-number width used on the controller interface, and the default
//   build parameters.
// ----------------------------------------------------------------------------
package elevator_call_dispatcher_pkg;

   // Width of the floor numbers exchanged with the elevator controller.
   localparam int FLOOR_W          = 4;

   // Default build: ten floors, short door dwell (simulation-sized).
   localparam int DEF_NUM_FLOORS   = 10;
   localparam int DEF_DWELL_CYCLES = 8;

   // Scheduler states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_UP    = 2'd1,
      ST_DOWN  = 2'd2,
      ST_DWELL = 2'd3
   } state_t;

endpackage

// File: rtl/elevator_call_dispatcher_sync.sv
// ----------------------------------------------------------------------------
// call_sync_edge
//   Brings the raw, asynchronous call buttons into the clock domain with a
//   2-flop synchronizer per bit, then turns each synchronized level into a
//   one-clock rising-edge pulse. Holding a button produces a single pulse.
//
// Ports
//   clk    in   single clock
//   rst_n  in   synchronous active-low reset; clears all flops
//   btn    in   WIDTH raw button levels
//   rise   out  WIDTH one-clock pulses on each synchronized 0->1 transition
// ----------------------------------------------------------------------------
module call_sync_edge #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] btn,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] meta;   // first stage, may go metastable
   logic [WIDTH-1:0] sync;   // second stage, safe to use
   logic [WIDTH-1:0] prev;   // sync delayed one clock for edge detection

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= '0;
         sync <= '0;
         prev <= '0;
      end else begin
         meta <= btn;
         sync <= meta;
         prev <= sync;
      end
   end

   // A button sampled high at edge k shows up here between edges k+1 and k+2.
   assign rise = sync & ~prev;

endmodule

// File: rtl/elevator_call_dispatcher.sv
// ----------------------------------------------------------------------------
// elevator_call_dispatcher
//   Latches per-floor call buttons as pending calls and feeds the elevator
//   controller a target floor chosen in SCAN order. A call is retired only
//   when the car is idle at the requested floor; the door is then held open
//   for DWELL_CYCLES clocks before the scan resumes.
//
// Ports
//   clk              in   single clock
//   rst_n            in   synchronous active-low reset
//   call_btn         in   NUM_FLOORS raw call buttons (async level)
//   current_floor    in   car position reported by the controller
//   car_idle         in   controller is parked / not moving
//   requested_floor  out  registered target floor for the controller
//   pending          out  latched calls, drives the call lamps
//   busy             out  scheduler is not in IDLE
//   door_open        out  scheduler is in DWELL
// ----------------------------------------------------------------------------
module elevator_call_dispatcher
   import elevator_call_dispatcher_pkg::*;
#(
   parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
   parameter int DWELL_CYCLES = DEF_DWELL_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] call_btn,
   input  logic [FLOOR_W-1:0]    current_floor,
   input  logic                  car_idle,
   output logic [FLOOR_W-1:0]    requested_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  busy,
   output logic                  door_open
);

   // Counter only has to hold DWELL_CYCLES-1.
   localparam int               CNT_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

   state_t                state;
   logic                  dir_up;     // last travel direction, 1 = up
   logic [CNT_W-1:0]      cnt;

   logic [NUM_FLOORS-1:0] rise;
   logic [NUM_FLOORS-1:0] cur_oh;     // one-hot of current_floor, zero if off-range
   logic [NUM_FLOORS-1:0] set_mask;
   logic [NUM_FLOORS-1:0] clr_mask;
   logic                  floor_ok;
   logic                  any_above;
   logic                  any_below;
   logic                  lo_found;   // some pending floor >= current_floor
   logic                  hi_found;   // some pending floor <= current_floor
   logic [FLOOR_W-1:0]    lo_floor;
   logic [FLOOR_W-1:0]    hi_floor;
   logic                  pend_cur;
   logic                  serve;
   logic                  exit_up;
   logic                  exit_down;

   call_sync_edge #(
      .WIDTH (NUM_FLOORS)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (call_btn),
      .rise  (rise)
   );

   // ------------------------------------------------------------------------
   // Floor scan. With the car reported off the end of the shaft, nothing is
   // treated as above, below, or at the car, so no call can be retired.
   // ------------------------------------------------------------------------
   always_comb begin
      floor_ok  = int'(current_floor) < NUM_FLOORS;
      cur_oh    = '0;
      any_above = 1'b0;
      any_below = 1'b0;
      hi_found  = 1'b0;
      hi_floor  = current_floor;
      lo_found  = 1'b0;
      lo_floor  = current_floor;

      // Ascending pass: the last hit at or below the car is the highest one.
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (floor_ok) begin
            if (current_floor == FLOOR_W'(i))
               cur_oh[i] = 1'b1;
            if (pending[i] && (i > int'(current_floor)))
               any_above = 1'b1;
            if (pending[i] && (i < int'(current_floor)))
               any_below = 1'b1;
            if (pending[i] && (i <= int'(current_floor))) begin
               hi_found = 1'b1;
               hi_floor = FLOOR_W'(i);
            end
         end
      end

      // Descending pass: the last hit at or above the car is the lowest one.
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (floor_ok && pending[i] && (i >= int'(current_floor))) begin
            lo_found = 1'b1;
            lo_floor = FLOOR_W'(i);
         end
      end
   end

   assign pend_cur = |(pending & cur_oh);

   // The car must actually be parked at the floor we asked for.
   assign serve = (state != ST_DWELL) && car_idle &&
                  (requested_floor == current_floor) && pend_cur;

   // While the door is open at a floor, a fresh press of that floor's button
   // is already satisfied and is dropped.
   assign set_mask = rise & ~((state == ST_DWELL) ? cur_oh : '0);
   assign clr_mask = serve ? cur_oh : '0;

   // After dwell, keep the previous direction if it still has work.
   assign exit_up   = dir_up ? any_above : (!any_below && any_above);
   assign exit_down = dir_up ? (!any_above && any_below) : any_below;

   // ------------------------------------------------------------------------
   // Scheduler. busy/door_open are registered alongside every state change.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         dir_up          <= 1'b1;
         cnt             <= '0;
         pending         <= '0;
         requested_floor <= '0;
         busy            <= 1'b0;
         door_open       <= 1'b0;
      end else begin
         // Clear wins over a same-cycle set on the served floor.
         pending <= (pending | set_mask) & ~clr_mask;

         if (serve) begin
            state           <= ST_DWELL;
            cnt             <= CNT_LOAD;
            requested_floor <= current_floor;
            busy            <= 1'b1;
            door_open       <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (!pend_cur && any_above) begin
                     state           <= ST_UP;
                     dir_up          <= 1'b1;
                     busy            <= 1'b1;
                     requested_floor <= lo_floor;
                  end else if (!pend_cur && any_below) begin
                     state           <= ST_DOWN;
                     dir_up          <= 1'b0;
                     busy            <= 1'b1;
                     requested_floor <= hi_floor;
                  end else begin
                     // Parked, or a call at this floor waiting for car_idle.
                     requested_floor <= current_floor;
                  end
               end

               ST_UP: begin
                  if (lo_found) begin
                     // >= lets a car passing a new call retarget and stop.
                     requested_floor <= lo_floor;
                  end else if (any_below) begin
                     state           <= ST_DOWN;
                     dir_up          <= 1'b0;
                     requested_floor <= hi_floor;
                  end else begin
                     state           <= ST_IDLE;
                     busy            <= 1'b0;
                     requested_floor <= current_floor;
                  end
               end

               ST_DOWN: begin
                  if (hi_found) begin
                     requested_floor <= hi_floor;
                  end else if (any_above) begin
                     state           <= ST_UP;
                     dir_up          <= 1'b1;
                     requested_floor <= lo_floor;
                  end else begin
                     state           <= ST_IDLE;
                     busy            <= 1'b0;
                     requested_floor <= current_floor;
                  end
               end

               ST_DWELL: begin
                  if (cnt != '0) begin
                     cnt             <= cnt - CNT_W'(1);
                     requested_floor <= current_floor;
                  end else begin
                     door_open <= 1'b0;
                     if (exit_up) begin
                        state           <= ST_UP;
                        dir_up          <= 1'b1;
                        requested_floor <= lo_floor;
                     end else if (exit_down) begin
                        state           <= ST_DOWN;
                        dir_up          <= 1'b0;
                        requested_floor <= hi_floor;
                     end else begin
                        state           <= ST_IDLE;
                        busy            <= 1'b0;
                        requested_floor <= current_floor;
                     end
                  end
               end

               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_elevator_call_dispatcher
//   Scenario tasks plus a randomized run against a behavioural model of the
//   dispatcher rules and a simple car that crawls one floor every MOVE clocks
//   toward the model's requested floor.
// ----------------------------------------------------------------------------
module tb_elevator_call_dispatcher;

   localparam int N    = 10;
   localparam int D    = 8;
   localparam int MOVE = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] call_btn = '0;
   logic [3:0]   current_floor = 4'd0;
   logic         car_idle = 1'b1;
   logic [3:0]   requested_floor;
   logic [N-1:0] pending;
   logic         busy;
   logic         door_open;

   int n_cmp = 0;
   int n_bad = 0;

   elevator_call_dispatcher #(
      .NUM_FLOORS   (N),
      .DWELL_CYCLES (D)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .call_btn        (call_btn),
      .current_floor   (current_floor),
      .car_idle        (car_idle),
      .requested_floor (requested_floor),
      .pending         (pending),
      .busy            (busy),
      .door_open       (door_open)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // mode: "idle", "up", "down", "dwell"
   string m_mode = "idle";
   bit    m_goes_up = 1'b1;
   int    m_left = 0;           // dwell clocks still to go after this one
   int    m_req = 0;
   bit    m_pend[N];
   bit    m_btn_d1[N], m_btn_d2[N], m_btn_d3[N];
   bit    car_en = 1'b0;
   int    car_mv = 0;

   function automatic logic [N-1:0] m_pend_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic head(input string md, input int tgt);
      m_mode = md;
      m_req  = tgt;
      if (md == "up")   m_goes_up = 1'b1;
      if (md == "down") m_goes_up = 1'b0;
   endtask

   task automatic model_step();
      int cf = int'(current_floor);
      bit on_shaft = (cf < N);
      bit press[N];
      bit up_work = 0, down_work = 0, here, serve;
      int lo = -1, hi = -1;
      for (int i = 0; i < N; i++) press[i] = m_btn_d2[i] && !m_btn_d3[i];
      if (!rst_n) begin
         m_mode = "idle"; m_goes_up = 1'b1; m_left = 0; m_req = 0;
         for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_btn_d1[i] = 0; m_btn_d2[i] = 0; m_btn_d3[i] = 0;
         end
         return;
      end
      for (int i = 0; i < N; i++) begin
         m_btn_d3[i] = m_btn_d2[i]; m_btn_d2[i] = m_btn_d1[i]; m_btn_d1[i] = call_btn[i];
      end
      if (on_shaft)
         for (int i = 0; i < N; i++)
            if (m_pend[i]) begin
               if (i > cf) up_work = 1;
               if (i < cf) down_work = 1;
               if (i >= cf && lo < 0) lo = i;
               if (i <= cf) hi = i;
            end
      here  = on_shaft ? m_pend[cf] : 1'b0;
      serve = (m_mode != "dwell") && car_idle && (m_req == cf) && here;
      for (int i = 0; i < N; i++)
         if (press[i] && !(m_mode == "dwell" && i == cf)) m_pend[i] = 1;
      if (serve) begin
         m_pend[cf] = 0; m_mode = "dwell"; m_left = D - 1; m_req = cf;
      end else if (m_mode == "idle") begin
         if (here)           m_req = cf;
         else if (up_work)   head("up", lo);
         else if (down_work) head("down", hi);
         else                m_req = cf;
      end else if (m_mode == "up") begin
         if (lo >= 0)        m_req = lo;
         else if (down_work) head("down", hi);
         else                head("idle", cf);
      end else if (m_mode == "down") begin
         if (hi >= 0)        m_req = hi;
         else if (up_work)   head("up", lo);
         else                head("idle", cf);
      end else begin
         if (m_left > 0) begin
            m_left--; m_req = cf;
         end else if (m_goes_up ? up_work : (!down_work && up_work)) head("up", lo);
         else if (m_goes_up ? (!up_work && down_work) : down_work) head("down", hi);
         else head("idle", cf);
      end
   endtask

   task automatic car_step();
      int cf = int'(current_floor);
      if (!car_en) return;
      if (cf != m_req) begin
         car_mv++;
         if (car_mv >= MOVE) begin
            car_mv = 0;
            cf = (m_req > cf) ? cf + 1 : cf - 1;
         end
      end else car_mv = 0;
      current_floor = 4'(cf);
      car_idle      = (cf == m_req);
   endtask

   // One clock: inputs are only ever changed 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
      car_step();
   endtask

   task automatic do_reset(input int floor);
      car_en = 1'b0; car_mv = 0;
      current_floor = 4'(floor); car_idle = 1'b1; call_btn = '0;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic press(input int f, input int clocks);
      call_btn[f] = 1'b1;
      repeat (clocks) tick();
      call_btn[f] = 1'b0;
   endtask

   // Records serves (floor, door-open length, bit already clear) until `want`
   // doors have closed or the budget runs out. Comparisons stay in callers.
   task automatic watch(input int want, input int budget, output int n,
                        output int order[4], output int lens[4], output bit clr[4]);
      bit prev = door_open;
      int len  = 0;
      n = 0;
      for (int i = 0; i < 4; i++) begin order[i] = -1; lens[i] = 0; clr[i] = 0; end
      for (int c = 0; c < budget && n < want; c++) begin
         tick();
         if (door_open && !prev && n < 4) begin
            order[n] = int'(current_floor);
            clr[n]   = (pending[current_floor] == 1'b0);
            len      = 0;
         end
         if (door_open) len++;
         if (prev && !door_open && n < 4) begin
            lens[n] = len;
            n++;
         end
         prev = door_open;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      car_en = 1'b0; current_floor = 4'd0; car_idle = 1'b1;
      rst_n = 1'b0; call_btn = '1;
      repeat (3) tick();
      n_cmp++; if (pending !== '0) begin n_bad++; $display("FAIL reset_pending got %h want 0", pending); end
      n_cmp++; if (requested_floor !== 4'd0) begin n_bad++; $display("FAIL reset_req got %0d want 0", requested_floor); end
      n_cmp++; if (busy !== 1'b0 || door_open !== 1'b0) begin n_bad++; $display("FAIL reset_flags got busy=%b door=%b want 0 0", busy, door_open); end
      call_btn = '0; tick();
      rst_n = 1'b1;
      repeat (4) tick();
      call_btn[3] = 1'b1;
      tick();   // edge k samples the press
      n_cmp++; if (pending[3] !== 1'b0) begin n_bad++; $display("FAIL latency_k got %b want 0", pending[3]); end
      tick();   // k+1
      n_cmp++; if (pending[3] !== 1'b0) begin n_bad++; $display("FAIL latency_k1 got %b want 0", pending[3]); end
      tick();   // k+2
      n_cmp++; if (pending[3] !== 1'b1) begin n_bad++; $display("FAIL latency_k2 got %b want 1", pending[3]); end
      tick();   // k+3
      n_cmp++; if (requested_floor !== 4'd3) begin n_bad++; $display("FAIL first_req got %0d want 3", requested_floor); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL first_busy got %b want 1", busy); end
      tick();
      n_cmp++; if (pending !== 10'h008) begin n_bad++; $display("FAIL hold_once got %h want 008", pending); end
      call_btn = '0;
   endtask

   task automatic test_two_calls();
      int n, order[4], lens[4]; bit clr[4];
      do_reset(0);
      car_en = 1'b1;
      call_btn[5] = 1'b1; call_btn[2] = 1'b1;
      repeat (2) tick();
      call_btn = '0;
      watch(2, 400, n, order, lens, clr);
      n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL two_calls_count got %0d want 2", n); end
      n_cmp++; if (order[0] !== 2 || order[1] !== 5) begin n_bad++; $display("FAIL two_calls_order got %0d,%0d want 2,5", order[0], order[1]); end
      n_cmp++; if (lens[0] !== D || lens[1] !== D) begin n_bad++; $display("FAIL dwell_len got %0d,%0d want %0d", lens[0], lens[1], D); end
      n_cmp++; if (!clr[0] || !clr[1]) begin n_bad++; $display("FAIL clear_at_serve got %b%b want 11", clr[0], clr[1]); end
   endtask

   task automatic test_retarget();
      int n, order[4], lens[4]; bit clr[4]; bit seen = 0;
      do_reset(0);
      car_en = 1'b1;
      press(7, 2);
      for (int c = 0; c < 200 && current_floor != 4'd2; c++) tick();
      n_cmp++; if (current_floor !== 4'd2) begin n_bad++; $display("FAIL reach_2 got %0d want 2", current_floor); end
      call_btn[4] = 1'b1;
      for (int c = 0; c < 8 && !seen; c++) begin
         tick();
         if (c == 1) call_btn[4] = 1'b0;
         seen = (requested_floor == 4'd4);
      end
      call_btn = '0;
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL retarget got %0d want 4", requested_floor); end
      watch(2, 400, n, order, lens, clr);
      n_cmp++; if (n !== 2 || order[0] !== 4 || order[1] !== 7) begin n_bad++; $display("FAIL retarget_order got %0d:%0d,%0d want 2:4,7", n, order[0], order[1]); end
   endtask

   task automatic test_down_dir();
      int n, order[4], lens[4]; bit clr[4];
      do_reset(6);
      car_en = 1'b1;
      press(1, 2);
      repeat (3) tick();
      press(8, 2);
      repeat (3) tick();
      n_cmp++; if (pending[8] !== 1'b1 || requested_floor !== 4'd1) begin n_bad++; $display("FAIL down_target got p8=%b req=%0d want 1,1", pending[8], requested_floor); end
      watch(2, 400, n, order, lens, clr);
      n_cmp++; if (n !== 2 || order[0] !== 1 || order[1] !== 8) begin n_bad++; $display("FAIL down_order got %0d:%0d,%0d want 2:1,8", n, order[0], order[1]); end
   endtask

   task automatic test_dwell_ignore();
      int len = 0; bit leaked = 0;
      do_reset(3);
      call_btn[3] = 1'b1;
      for (int c = 0; c < 10 && pending[3] !== 1'b1; c++) begin
         tick();
         if (c == 1) call_btn[3] = 1'b0;
      end
      call_btn = '0;
      n_cmp++; if (pending[3] !== 1'b1) begin n_bad++; $display("FAIL self_call_set got %b want 1", pending[3]); end
      tick();
      n_cmp++; if (door_open !== 1'b1 || pending[3] !== 1'b0) begin n_bad++; $display("FAIL self_serve got door=%b p3=%b want 1 0", door_open, pending[3]); end
      len = 1;
      call_btn[3] = 1'b1;
      for (int c = 0; c < 20 && door_open; c++) begin
         tick();
         if (c == 1) call_btn[3] = 1'b0;
         if (door_open) len++;
         if (pending[3]) leaked = 1;
      end
      call_btn = '0;
      repeat (3) tick();
      if (pending[3]) leaked = 1;
      n_cmp++; if (leaked) begin n_bad++; $display("FAIL dwell_press got set want discarded"); end
      n_cmp++; if (len !== D) begin n_bad++; $display("FAIL self_dwell_len got %0d want %0d", len, D); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL back_idle got busy=%b want 0", busy); end
   endtask

   task automatic test_off_shaft_and_reset();
      bit opened = 0;
      do_reset(12);
      press(9, 2);
      press(2, 2);
      for (int c = 0; c < 20; c++) begin
         tick();
         if (door_open) opened = 1;
      end
      n_cmp++; if (pending !== 10'h204 || opened) begin n_bad++; $display("FAIL off_shaft got p=%h door=%b want 204 0", pending, opened); end
      n_cmp++; if (requested_floor !== 4'd12 || busy !== 1'b0) begin n_bad++; $display("FAIL off_shaft_req got %0d busy=%b want 12 0", requested_floor, busy); end
      current_floor = 4'd9;
      for (int c = 0; c < 10 && !door_open; c++) tick();
      n_cmp++; if (door_open !== 1'b1 || pending !== 10'h004) begin n_bad++; $display("FAIL serve_9 got door=%b p=%h want 1 004", door_open, pending); end
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      n_cmp++; if (pending !== '0 || requested_floor !== 4'd0 || busy !== 1'b0 || door_open !== 1'b0) begin
         n_bad++; $display("FAIL mid_reset got p=%h req=%0d busy=%b door=%b want 0 0 0 0", pending, requested_floor, busy, door_open);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      int hold[N];
      do_reset(0);
      car_en = 1'b1;
      for (int i = 0; i < N; i++) hold[i] = 0;
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 11) == 0) hold[$urandom_range(0, N-1)] = $urandom_range(1, 4);
         for (int i = 0; i < N; i++) begin
            call_btn[i] = (hold[i] > 0);
            if (hold[i] > 0) hold[i]--;
         end
         tick();
         n_cmp++; if (pending !== m_pend_vec()) begin n_bad++; $display("FAIL rnd_pending cyc %0d got %h want %h", c, pending, m_pend_vec()); end
         n_cmp++; if (requested_floor !== 4'(m_req)) begin n_bad++; $display("FAIL rnd_req cyc %0d got %0d want %0d", c, requested_floor, m_req); end
         n_cmp++; if (busy !== (m_mode != "idle")) begin n_bad++; $display("FAIL rnd_busy cyc %0d got %b want %b", c, busy, m_mode != "idle"); end
         n_cmp++; if (door_open !== (m_mode == "dwell")) begin n_bad++; $display("FAIL rnd_door cyc %0d got %b want %b", c, door_open, m_mode == "dwell"); end
      end
      call_btn = '0;
   endtask

   initial begin
      test_reset();
      test_two_calls();
      test_retarget();
      test_down_dir();
      test_dwell_ignore();
      test_off_shaft_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
